muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_pkg.sv | 23 ++
 rtl/muldiv_if.sv | 14 +
 rtl/muldiv_dec.sv | 31 +++
 rtl/muldiv_unit.sv | 128 ++++++++++++
 tb/tb_muldiv_unit.sv | 137 +++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and defaults for the RV32M multiply/divide unit.
package muldiv_pkg;

  localparam int XLEN_DEF = 32;

  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } md_state_e;

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the core pipeline and the muldiv unit.
interface muldiv_if #(parameter int XLEN = muldiv_pkg::XLEN_DEF);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            flush;
  logic            ready;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (output start, funct3, a, b, flush, input ready, done, result);
  modport slave  (input start, funct3, a, b, flush, output ready, done, result);
endinterface

// File: rtl/muldiv_dec.sv
// funct3 decode into the handful of controls the datapath actually needs.
module muldiv_dec
  import muldiv_pkg::*;
(
  input  logic [2:0] i_funct3,
  output logic       o_is_div,
  output logic       o_a_signed,
  output logic       o_b_signed,
  output logic       o_sel_hi_rem
);

  // MUL low half is sign-agnostic, so it runs as an unsigned multiply.
  always_comb begin
    o_is_div     = 1'b0;
    o_a_signed   = 1'b0;
    o_b_signed   = 1'b0;
    o_sel_hi_rem = 1'b0;
    case (md_op_e'(i_funct3))
      MD_MUL:    ;
      MD_MULH:   begin o_a_signed = 1'b1; o_b_signed = 1'b1; o_sel_hi_rem = 1'b1; end
      MD_MULHSU: begin o_a_signed = 1'b1; o_sel_hi_rem = 1'b1; end
      MD_MULHU:  o_sel_hi_rem = 1'b1;
      MD_DIV:    begin o_is_div = 1'b1; o_a_signed = 1'b1; o_b_signed = 1'b1; end
      MD_DIVU:   o_is_div = 1'b1;
      MD_REM:    begin o_is_div = 1'b1; o_a_signed = 1'b1; o_b_signed = 1'b1; o_sel_hi_rem = 1'b1; end
      MD_REMU:   begin o_is_div = 1'b1; o_sel_hi_rem = 1'b1; end
      default:   ;
    endcase
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M unit: one bit per cycle shift-add multiply / restoring
// divide on magnitudes, sign fix-up on the way into DONE.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic     clk,
  input  logic     reset,
  muldiv_if.slave  bus
);

  localparam int             CW       = $clog2(XLEN + 1);
  localparam logic [CW-1:0]  CNT_INIT = CW'(XLEN);

  md_state_e       r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_hi, r_lo, r_b_mag, r_result;
  logic            r_is_div, r_sel, r_a_neg, r_b_neg;

  logic            w_is_div, w_a_signed, w_b_signed, w_sel;
  logic            w_accept, w_a_neg, w_b_neg, w_div0, w_ovf, w_bypass, w_step_en, w_fix_en;
  logic [XLEN-1:0] w_a_mag, w_b_mag, w_bypass_res;
  logic [XLEN:0]   w_mul_sum;
  logic [XLEN+1:0] w_div_diff;
  logic            w_div_ok;
  logic [2*XLEN-1:0] w_prod, w_prod_fix;
  logic [XLEN-1:0] w_quo_fix, w_rem_fix, w_final;

  muldiv_dec u_dec (
    .i_funct3     (bus.funct3),
    .o_is_div     (w_is_div),
    .o_a_signed   (w_a_signed),
    .o_b_signed   (w_b_signed),
    .o_sel_hi_rem (w_sel)
  );

  assign w_accept  = bus.start & (r_state == ST_IDLE) & ~bus.flush;
  assign w_a_neg   = w_a_signed & bus.a[XLEN-1];
  assign w_b_neg   = w_b_signed & bus.b[XLEN-1];
  assign w_a_mag   = w_a_neg ? -bus.a : bus.a;
  assign w_b_mag   = w_b_neg ? -bus.b : bus.b;

  // Special divide cases finish straight from IDLE with a fixed answer.
  assign w_div0    = w_is_div & (bus.b == '0);
  assign w_ovf     = w_is_div & w_a_signed & (bus.a == {1'b1, {(XLEN-1){1'b0}}}) & (&bus.b);
  assign w_bypass  = w_div0 | w_ovf;
  assign w_bypass_res = w_div0 ? (w_sel ? bus.a : '1) : (w_sel ? '0 : bus.a);

  // Counter runs XLEN..1 doing one bit each; the cnt==0 CALC cycle is the sign fix-up.
  assign w_step_en = (r_state == ST_CALC) & (r_cnt != '0) & ~bus.flush;
  assign w_fix_en  = (r_state == ST_CALC) & (r_cnt == '0) & ~bus.flush;

  // Multiply: {r_hi,r_lo} is product-high : multiplier, shifted right each step.
  assign w_mul_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b_mag} : '0);
  // Divide: r_hi is the partial remainder, r_lo shifts dividend out / quotient in.
  assign w_div_diff = {1'b0, r_hi, r_lo[XLEN-1]} - {2'b00, r_b_mag};
  assign w_div_ok   = ~w_div_diff[XLEN+1];

  assign w_prod     = {r_hi, r_lo};
  assign w_prod_fix = (r_a_neg ^ r_b_neg) ? -w_prod : w_prod;
  assign w_quo_fix  = (r_a_neg ^ r_b_neg) ? -r_lo : r_lo;
  assign w_rem_fix  = r_a_neg ? -r_hi : r_hi;
  assign w_final    = r_is_div ? (r_sel ? w_rem_fix : w_quo_fix)
                               : (r_sel ? w_prod_fix[2*XLEN-1:XLEN] : w_prod_fix[XLEN-1:0]);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state: flush always wins and returns to IDLE.
  always_comb begin
    w_state_nxt = r_state;
    if (bus.flush) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (w_accept) w_state_nxt = w_bypass ? ST_DONE : ST_CALC;
        ST_CALC: if (r_cnt == '0) w_state_nxt = ST_DONE;
        ST_DONE: w_state_nxt = ST_IDLE;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Operand capture, per-bit iteration and result latch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_b_mag  <= '0;
      r_result <= '0;
      r_is_div <= 1'b0;
      r_sel    <= 1'b0;
      r_a_neg  <= 1'b0;
      r_b_neg  <= 1'b0;
    end else if (w_accept) begin
      r_cnt    <= CNT_INIT;
      r_hi     <= '0;
      r_lo     <= w_a_mag;
      r_b_mag  <= w_b_mag;
      r_is_div <= w_is_div;
      r_sel    <= w_sel;
      r_a_neg  <= w_a_neg;
      r_b_neg  <= w_b_neg;
      if (w_bypass) r_result <= w_bypass_res;
    end else if (w_step_en) begin
      r_cnt <= r_cnt - 1'b1;
      if (r_is_div) begin
        r_hi <= w_div_ok ? w_div_diff[XLEN-1:0] : {r_hi[XLEN-2:0], r_lo[XLEN-1]};
        r_lo <= {r_lo[XLEN-2:0], w_div_ok};
      end else begin
        r_hi <= w_mul_sum[XLEN:1];
        r_lo <= {w_mul_sum[0], r_lo[XLEN-1:1]};
      end
    end else if (w_fix_en) begin
      r_result <= w_final;
    end
  end

  assign bus.ready  = (r_state == ST_IDLE);
  assign bus.done   = (r_state == ST_DONE) & ~bus.flush;
  assign bus.result = r_result;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit at XLEN=32.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  muldiv_if #(.XLEN(32)) bus();
  muldiv_unit #(.XLEN(32)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a request just after a rising edge; it is accepted on the next one.
  task automatic launch(input md_op_e op, input logic [31:0] av, input logic [31:0] bv);
    bus.start = 1'b1; bus.funct3 = op; bus.a = av; bus.b = bv;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.a = 32'h5A5A_5A5A; bus.b = 32'hA5A5_A5A5;
  endtask

  // Count falling edges after the accept edge until done (bounded).
  task automatic wait_done(input string tag, input int n0, input int exp_lat, input logic [31:0] exp_res);
    int n;
    bit seen;
    n = n0; seen = 1'b0;
    while (!seen && n < 100) begin
      @(negedge clk); n++;
      if (bus.done === 1'b1) seen = 1'b1;
    end
    check({tag, " latency"}, 64'(n), 64'(exp_lat));
    check({tag, " result"}, 64'(bus.result), 64'(exp_res));
    @(negedge clk);
    check({tag, " single pulse"}, 64'(bus.done), 64'd0);
  endtask

  task automatic run(input string tag, input md_op_e op, input logic [31:0] av,
                     input logic [31:0] bv, input int lat, input logic [31:0] res);
    check({tag, " ready"}, 64'(bus.ready), 64'd1);
    launch(op, av, bv);
    wait_done(tag, 0, lat, res);
  endtask

  task automatic count_dones(input string tag, input int cycles);
    int d;
    d = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (bus.done === 1'b1) d++;
    end
    check(tag, 64'(d), 64'd0);
  endtask

  initial begin
    bus.start = 1'b0; bus.flush = 1'b0; bus.funct3 = 3'b000; bus.a = '0; bus.b = '0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("reset ready",  64'(bus.ready),  64'd1);
    check("reset done",   64'(bus.done),   64'd0);
    check("reset result", 64'(bus.result), 64'd0);

    // Release and request in the very first cycle out of reset.
    @(posedge clk); #1; reset = 1'b0;
    run("MUL 7*-3",   MD_MUL,    32'd7,          32'hFFFF_FFFD, 34, 32'hFFFF_FFEB);
    run("MULHU",      MD_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 34, 32'hFFFF_FFFE);
    run("MULH",       MD_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 34, 32'h0000_0000);
    run("MULHSU",     MD_MULHSU, 32'hFFFF_FFFF,  32'd2,         34, 32'hFFFF_FFFF);
    run("DIV -7/2",   MD_DIV,    32'hFFFF_FFF9,  32'd2,         34, 32'hFFFF_FFFD);
    run("REM -7%2",   MD_REM,    32'hFFFF_FFF9,  32'd2,         34, 32'hFFFF_FFFF);
    run("DIVU 100/7", MD_DIVU,   32'd100,        32'd7,         34, 32'd14);
    run("REMU 100%7", MD_REMU,   32'd100,        32'd7,         34, 32'd2);
    run("DIVU /0",    MD_DIVU,   32'd5,          32'd0,         1,  32'hFFFF_FFFF);
    run("REM /0",     MD_REM,    32'd5,          32'd0,         1,  32'd5);
    run("DIV ovf",    MD_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 1,  32'h8000_0000);
    run("REM ovf",    MD_REM,    32'h8000_0000,  32'hFFFF_FFFF, 1,  32'd0);

    // Start pulsed mid-operation must not disturb the multiply in flight.
    launch(MD_MUL, 32'd3, 32'd5);
    repeat (4) @(negedge clk);
    bus.start = 1'b1; bus.funct3 = MD_DIVU; bus.a = 32'd100; bus.b = 32'd0;
    @(negedge clk);
    check("busy ready", 64'(bus.ready), 64'd0);
    bus.start = 1'b0;
    wait_done("MUL ignore start", 5, 34, 32'd15);

    // Flush at cycle 10 kills the operation with no done and no result change.
    launch(MD_MUL, 32'd9, 32'd9);
    repeat (9) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush ready",  64'(bus.ready),  64'd1);
    check("flush result", 64'(bus.result), 64'd15);
    count_dones("flush no done", 40);
    check("flush result held", 64'(bus.result), 64'd15);

    // Flush and start together: no accept.
    bus.start = 1'b1; bus.flush = 1'b1; bus.funct3 = MD_DIVU; bus.a = 32'd5; bus.b = 32'd0;
    @(negedge clk);
    bus.start = 1'b0; bus.flush = 1'b0;
    check("flush+start ready", 64'(bus.ready), 64'd1);
    count_dones("flush+start no done", 5);
    check("flush+start result", 64'(bus.result), 64'd15);

    // Reset at cycle 12 of a divide.
    launch(MD_DIV, 32'hFFFF_FFF9, 32'd2);
    repeat (11) @(negedge clk);
    #2; reset = 1'b1;
    #1;
    check("midop reset ready",  64'(bus.ready),  64'd1);
    check("midop reset done",   64'(bus.done),   64'd0);
    check("midop reset result", 64'(bus.result), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    count_dones("after reset no done", 40);
    run("DIVU after reset", MD_DIVU, 32'd100, 32'd7, 34, 32'd14);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
